snow64_param_float_div: RTL and testbench
=========================================

# snow64_param_float_div

Parametrised multi-cycle floating-point divider. It is the next generation of the BFloat16 divider: exponent and mantissa widths are configurable, round-to-nearest-even is selectable, and exception flags are reported. It sits beside the other Snow64 float units behind the same start / can_accept_cmd / data_valid command handshake. Defaults give BFloat16.

## Interface
- EXP_WIDTH, 8: encoded exponent width (≥3).
- MANT_WIDTH, 7: encoded mantissa width (≥2).
- ROUND_NEAREST, 1: 1 = round-to-nearest-even; 0 = truncate.
- clk  in  1  clock. One clock; all state on posedge clk.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  command request; sampled only while can_accept_cmd=1.
- a  in  W=1+EXP_WIDTH+MANT_WIDTH  dividend, layout {sign, enc_exp, enc_mantissa}.
- b  in  W  divisor, same layout.
- data  out  W  quotient; holds until the next result.
- data_valid  out  1  one-cycle pulse when data/flags update.
- can_accept_cmd  out  1  high when idle.
- div_by_zero, overflow, underflow  out  1 each  flags; updated with data.

## Operation
- Number format:
  - enc_exp==0 means zero; there are no denormals.
  - All other encodings are finite, including enc_exp all-ones. No inf or NaN.
  - BIAS = 2^(EXP_WIDTH-1)-1; MAXE = 2^EXP_WIDTH-1.
- States: IDLE → DIVIDE (N=MANT_WIDTH+3 cycles) → NORM_ROUND (1) → FINISH (1) → IDLE.
- IDLE, start=1:
  - Capture a and b.
  - sign = a.sign^b.sign.
  - sa={1,a.mant}, sb={1,b.mant}, each MANT_WIDTH+1 bits.
  - Remainder r=sa, held in MANT_WIDTH+2 bits.
  - Exponent e = a.exp − b.exp + BIAS, signed, EXP_WIDTH+2 bits.
  - can_accept_cmd←0.
- DIVIDE: restoring radix-2, one quotient bit per cycle, MSB first.
  - Each cycle: q_bit=(r≥sb); if set, r−=sb; then r<<=1.
  - Iteration counter runs 0..N-1.
- NORM_ROUND, sticky s = (r≠0):
  - If q[N-1]=1: mant=q[MANT_WIDTH+1:2], guard=q[1], s|=q[0].
  - Otherwise: mant=q[MANT_WIDTH:1], guard=q[0], e−=1.
  - If ROUND_NEAREST and guard && (s || mant[0]): mant+=1.
  - If that increment carries out, mant=0 and e+=1.
- FINISH, priority order:
  1. b.exp==0: result {sign,0,0}; div_by_zero=1.
  2. a.exp==0: result {sign,0,0}.
  3. e≤0: result {sign,0,0}; underflow=1.
  4. e≥MAXE: result {sign,MAXE−1,all-ones}; overflow=1.
  5. Otherwise: result {sign,e[EXP_WIDTH-1:0],mant}.
  - Flags not set by a case are cleared.
  - data_valid←1; can_accept_cmd←1; state←IDLE.
- Zero operands still take the full latency, so latency is fixed.

## Timing
- Reset values (async on rst_n low): state=IDLE, data=0, all flags 0, data_valid=0, can_accept_cmd=1, internal registers 0.
- Latency: start accepted at edge 0 → data_valid high for exactly the one cycle after edge N+2. BFloat16: 12 cycles.
- data_valid and can_accept_cmd rise together.
- A start in that same cycle is accepted, so back-to-back throughput is one result per N+3 cycles.
- start while can_accept_cmd=0 is ignored; there is no queueing.
- a and b are sampled only at the accept edge; later changes have no effect.
- rst_n asserted mid-operation aborts the operation immediately, and no data_valid is produced for it.
- After rst_n deasserts, the first posedge may accept a start.

## Test plan
1. Defaults, 0x3F80 / 0x4000 → 0x3F00, no flags, data_valid exactly 12 cycles after start.
2. 0x4040 / 0x3FC0 → 0x4000. 0x3F80 / 0x4040 → 0x3EAB with ROUND_NEAREST=1; → 0x3EAA with ROUND_NEAREST=0.
3. 0xC000 / 0x0000 → 0x8000, div_by_zero=1. 0x0000 / 0x4000 → 0x0000, no flags.
4. 0x7F00 / 0x0080 → 0x7F7F, overflow=1. 0x0080 / 0x7F00 → 0x0000, underflow=1.
5. Two back-to-back commands, the second start issued in the data_valid cycle:
   - two results 13 cycles apart;
   - a start pulsed while busy is ignored.
6. rst_n pulsed at cycle 5 of a divide:
   - outputs at reset values immediately;
   - no stale data_valid;
   - the next command gives the correct result.
   - Also run with EXP_WIDTH=5, MANT_WIDTH=10: 0x3C00/0x4000 → 0x3800, latency 15.

Source files
------------

// File: rtl/snow64_param_float_div_if.sv
// Command/result bundle for the Snow64 parametrised float divider.
// The master side issues start/a/b; the slave side returns the quotient and flags.
interface snow64_param_float_div_if #(
    parameter int W = 16
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] data;
    logic         data_valid;
    logic         can_accept_cmd;
    logic         div_by_zero;
    logic         overflow;
    logic         underflow;

    modport master (
        output start, a, b,
        input  data, data_valid, can_accept_cmd, div_by_zero, overflow, underflow
    );

    modport slave (
        input  start, a, b,
        output data, data_valid, can_accept_cmd, div_by_zero, overflow, underflow
    );
endinterface

// File: rtl/snow64_param_float_div.sv
// Multi-cycle parametrised float divider (restoring radix-2, one quotient bit per cycle).
// Fixed latency of MANT_WIDTH+5 edges from accept to result, including zero operands.
module snow64_param_float_div #(
    parameter int EXP_WIDTH     = 8,
    parameter int MANT_WIDTH    = 7,
    parameter int ROUND_NEAREST = 1
) (
    input logic                     clk,
    input logic                     rst_n,
    snow64_param_float_div_if.slave bus
);
    localparam int W    = 1 + EXP_WIDTH + MANT_WIDTH;
    localparam int N    = MANT_WIDTH + 3;
    localparam int EW2  = EXP_WIDTH + 2;
    localparam int CW   = $clog2(N);
    localparam int BIAS = (1 << (EXP_WIDTH - 1)) - 1;
    localparam int MAXE = (1 << EXP_WIDTH) - 1;

    localparam logic signed [EW2-1:0] E_BIAS = EW2'(BIAS);
    localparam logic signed [EW2-1:0] E_MAXE = EW2'(MAXE);
    localparam logic signed [EW2-1:0] E_ZERO = '0;
    localparam logic signed [EW2-1:0] E_ONE  = EW2'(1);
    localparam logic [EXP_WIDTH-1:0]  EXP_SAT = {{(EXP_WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, DIVIDE, NORM_ROUND, FINISH} state_t;

    state_t state_q, state_d;

    // operand fields
    logic                  a_sign, b_sign;
    logic [EXP_WIDTH-1:0]  a_exp, b_exp;
    logic [MANT_WIDTH-1:0] a_mant, b_mant;

    assign a_sign = bus.a[W-1];
    assign b_sign = bus.b[W-1];
    assign a_exp  = bus.a[W-2:MANT_WIDTH];
    assign b_exp  = bus.b[W-2:MANT_WIDTH];
    assign a_mant = bus.a[MANT_WIDTH-1:0];
    assign b_mant = bus.b[MANT_WIDTH-1:0];

    // datapath registers
    logic                  sign_q, sign_d;
    logic                  a_zero_q, a_zero_d;
    logic                  b_zero_q, b_zero_d;
    logic [MANT_WIDTH:0]   sb_q, sb_d;
    logic [MANT_WIDTH+1:0] r_q, r_d;
    logic [N-1:0]          q_q, q_d;
    logic signed [EW2-1:0] e_q, e_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [MANT_WIDTH-1:0] mant_q, mant_d;
    logic [W-1:0]          data_q, data_d;
    logic                  dv_q, dv_d;
    logic                  dz_q, dz_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    // FSM decode
    logic can_accept, accept, last_iter;

    // ------------------------------------------------------------------
    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign last_iter = (cnt_q == CW'(N - 1));

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (bus.start) state_d = DIVIDE;
            DIVIDE:     if (last_iter) state_d = NORM_ROUND;
            NORM_ROUND: state_d = FINISH;
            FINISH:     state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        can_accept = (state_q == IDLE);
        accept     = can_accept && bus.start;
    end

    // ------------------------------------------------------------------
    // datapath next-state
    logic                  ge;
    logic [MANT_WIDTH+1:0] r_sub;
    logic [MANT_WIDTH-1:0] mant_sel;
    logic                  guard, sticky;
    logic signed [EW2-1:0] e_adj;
    logic [MANT_WIDTH:0]   rnd;

    always_comb begin
        sign_d   = sign_q;
        a_zero_d = a_zero_q;
        b_zero_d = b_zero_q;
        sb_d     = sb_q;
        r_d      = r_q;
        q_d      = q_q;
        e_d      = e_q;
        cnt_d    = cnt_q;
        mant_d   = mant_q;
        data_d   = data_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        dv_d     = 1'b0;

        ge       = (r_q >= {1'b0, sb_q});
        r_sub    = ge ? (r_q - {1'b0, sb_q}) : r_q;

        // quotient lies in (0.5, 2): pick the window by its integer bit
        if (q_q[N-1]) begin
            mant_sel = q_q[MANT_WIDTH+1:2];
            guard    = q_q[1];
            sticky   = (|r_q) | q_q[0];
            e_adj    = e_q;
        end else begin
            mant_sel = q_q[MANT_WIDTH:1];
            guard    = q_q[0];
            sticky   = |r_q;
            e_adj    = e_q - E_ONE;
        end
        rnd = {1'b0, mant_sel} + (MANT_WIDTH+1)'(1);

        case (state_q)
            IDLE: if (accept) begin
                sign_d   = a_sign ^ b_sign;
                a_zero_d = (a_exp == '0);
                b_zero_d = (b_exp == '0);
                sb_d     = {1'b1, b_mant};
                r_d      = {2'b01, a_mant};
                q_d      = '0;
                e_d      = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + E_BIAS;
                cnt_d    = '0;
            end
            DIVIDE: begin
                q_d   = {q_q[N-2:0], ge};
                r_d   = {r_sub[MANT_WIDTH:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
            end
            NORM_ROUND: begin
                if ((ROUND_NEAREST != 0) && guard && (sticky || mant_sel[0])) begin
                    mant_d = rnd[MANT_WIDTH-1:0];
                    e_d    = rnd[MANT_WIDTH] ? (e_adj + E_ONE) : e_adj;
                end else begin
                    mant_d = mant_sel;
                    e_d    = e_adj;
                end
            end
            FINISH: begin
                dz_d  = 1'b0;
                ovf_d = 1'b0;
                unf_d = 1'b0;
                dv_d  = 1'b1;
                if (b_zero_q) begin
                    data_d = {sign_q, {(W-1){1'b0}}};
                    dz_d   = 1'b1;
                end else if (a_zero_q) begin
                    data_d = {sign_q, {(W-1){1'b0}}};
                end else if (e_q <= E_ZERO) begin
                    data_d = {sign_q, {(W-1){1'b0}}};
                    unf_d  = 1'b1;
                end else if (e_q >= E_MAXE) begin
                    data_d = {sign_q, EXP_SAT, {MANT_WIDTH{1'b1}}};
                    ovf_d  = 1'b1;
                end else begin
                    data_d = {sign_q, e_q[EXP_WIDTH-1:0], mant_q};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q   <= 1'b0;
            a_zero_q <= 1'b0;
            b_zero_q <= 1'b0;
            sb_q     <= '0;
            r_q      <= '0;
            q_q      <= '0;
            e_q      <= '0;
            cnt_q    <= '0;
            mant_q   <= '0;
            data_q   <= '0;
            dv_q     <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            sign_q   <= sign_d;
            a_zero_q <= a_zero_d;
            b_zero_q <= b_zero_d;
            sb_q     <= sb_d;
            r_q      <= r_d;
            q_q      <= q_d;
            e_q      <= e_d;
            cnt_q    <= cnt_d;
            mant_q   <= mant_d;
            data_q   <= data_d;
            dv_q     <= dv_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign bus.data           = data_q;
    assign bus.data_valid     = dv_q;
    assign bus.can_accept_cmd = can_accept;
    assign bus.div_by_zero    = dz_q;
    assign bus.overflow       = ovf_q;
    assign bus.underflow      = unf_q;
endmodule

// File: tb/tb_snow64_param_float_div.sv
// Scoreboard bench: three divider configs (BF16 RNE, BF16 truncate, FP16 RNE).
// Drivers push expected results; a negedge monitor pops and compares on data_valid.
module tb_snow64_param_float_div;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    snow64_param_float_div_if #(.W(16)) bus0 ();
    snow64_param_float_div_if #(.W(16)) bus1 ();
    snow64_param_float_div_if #(.W(16)) bus2 ();

    snow64_param_float_div #(.EXP_WIDTH(8), .MANT_WIDTH(7), .ROUND_NEAREST(1))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    snow64_param_float_div #(.EXP_WIDTH(8), .MANT_WIDTH(7), .ROUND_NEAREST(0))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    snow64_param_float_div #(.EXP_WIDTH(5), .MANT_WIDTH(10), .ROUND_NEAREST(1))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct {
        logic [15:0] data;
        logic [2:0]  flags;
        int          cyc;
    } exp_t;

    exp_t sbq[3][$];
    int   lat[3] = '{12, 12, 15};

    logic [15:0] dat[3];
    logic [2:0]  fl[3];
    logic        dv[3];
    logic        ca[3];

    assign dat[0] = bus0.data;
    assign dat[1] = bus1.data;
    assign dat[2] = bus2.data;
    assign fl[0]  = {bus0.div_by_zero, bus0.overflow, bus0.underflow};
    assign fl[1]  = {bus1.div_by_zero, bus1.overflow, bus1.underflow};
    assign fl[2]  = {bus2.div_by_zero, bus2.overflow, bus2.underflow};
    assign dv[0]  = bus0.data_valid;
    assign dv[1]  = bus1.data_valid;
    assign dv[2]  = bus2.data_valid;
    assign ca[0]  = bus0.can_accept_cmd;
    assign ca[1]  = bus1.can_accept_cmd;
    assign ca[2]  = bus2.can_accept_cmd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    // monitor: every data_valid must match the oldest outstanding expectation
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst_n && dv[d]) begin
                exp_t e;
                if (sbq[d].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL dut%0d unexpected data_valid: got data 0x%0h expected none", d, dat[d]);
                end else begin
                    e = sbq[d].pop_front();
                    chk($sformatf("dut%0d data", d), 32'(dat[d]), 32'(e.data));
                    chk($sformatf("dut%0d flags{dz,ovf,unf}", d), 32'(fl[d]), 32'(e.flags));
                    chk($sformatf("dut%0d valid cycle", d), 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic drive(input int d, input logic s, input logic [15:0] a, input logic [15:0] b);
        case (d)
            0: begin bus0.start = s; bus0.a = a; bus0.b = b; end
            1: begin bus1.start = s; bus1.a = a; bus1.b = b; end
            default: begin bus2.start = s; bus2.a = a; bus2.b = b; end
        endcase
    endtask

    // wait for can_accept_cmd, present one command, return the accept edge number
    task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] r, input logic [2:0] f, output int acc);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!ca[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ca[d]) begin
            tests++;
            fails++;
            $display("FAIL dut%0d accept timeout: got can_accept_cmd 0 expected 1", d);
        end
        drive(d, 1'b1, a, b);
        acc    = cyc + 1;
        e.data = r;
        e.flags = f;
        e.cyc  = acc + lat[d];
        sbq[d].push_back(e);
        @(posedge clk);
        #1 drive(d, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic chk_reset(input int d);
        chk($sformatf("dut%0d reset data", d), 32'(dat[d]), 32'h0);
        chk($sformatf("dut%0d reset flags", d), 32'(fl[d]), 32'h0);
        chk($sformatf("dut%0d reset data_valid", d), 32'(dv[d]), 32'h0);
        chk($sformatf("dut%0d reset can_accept_cmd", d), 32'(ca[d]), 32'h1);
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("scoreboard drained", 32'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 32'h0);
    endtask

    // BF16 round-to-nearest vectors: a, b, quotient, flags{dz,ovf,unf}
    logic [15:0] va[6] = '{16'h3F80, 16'h4040, 16'h3F80, 16'hC000, 16'h0000, 16'h0080};
    logic [15:0] vb[6] = '{16'h4000, 16'h3FC0, 16'h4040, 16'h0000, 16'h4000, 16'h7F00};
    logic [15:0] vr[6] = '{16'h3F00, 16'h4000, 16'h3EAB, 16'h8000, 16'h0000, 16'h0000};
    logic [2:0]  vf[6] = '{3'b000,   3'b000,   3'b000,   3'b100,   3'b000,   3'b001};

    initial begin
        int acc, acc1, acc2;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 16'h0000, 16'h0000);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk_reset(d);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) issue(0, va[i], vb[i], vr[i], vf[i], acc);
        issue(1, 16'h3F80, 16'h4040, 16'h3EAA, 3'b000, acc);
        issue(1, 16'h3F80, 16'h4000, 16'h3F00, 3'b000, acc);
        issue(2, 16'h3C00, 16'h4000, 16'h3800, 3'b000, acc);
        drain();

        // back-to-back with a start pulsed while busy
        issue(0, 16'h4040, 16'h3FC0, 16'h4000, 3'b000, acc1);
        @(negedge clk);
        chk("dut0 busy can_accept_cmd", 32'(ca[0]), 32'h0);
        drive(0, 1'b1, 16'h3F80, 16'h3F80);
        @(posedge clk);
        #1 drive(0, 1'b0, 16'h0000, 16'h0000);
        issue(0, 16'h3F80, 16'h4040, 16'h3EAB, 3'b000, acc2);
        chk("back-to-back accept spacing", 32'(acc2 - acc1), 32'd13);
        drain();

        // leave a nonzero result and flag behind, then abort a divide with reset
        issue(0, 16'h7F00, 16'h0080, 16'h7F7F, 3'b010, acc);
        drain();
        issue(0, 16'h3F80, 16'h4000, 16'h3F00, 3'b000, acc);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        sbq[0].delete();
        #1 chk_reset(0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        issue(0, 16'h3F80, 16'h4040, 16'h3EAB, 3'b000, acc);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
